// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared Avalon-MM types and requester IDs for the two-master bus arbiter.
package avalon_bus_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [AddrW-1:0] address;
    logic [DataW-1:0] writedata;
    logic [BeW-1:0]   byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [DataW-1:0] readdata;
    logic             readdatavalid;
    logic             waitrequest;
  } avalon_resp_t;

  typedef enum logic {
    ARB_ID_IBUS = 1'b0,
    ARB_ID_DBUS = 1'b1
  } arb_id_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic req_active(input avalon_req_t r);
    return r.read | r.write;
  endfunction

  // A write can always go; a read needs a free slot in the ID FIFO.
  function automatic logic req_eligible(input avalon_req_t r, input logic fifo_full);
    return r.write | (r.read & ~fifo_full);
  endfunction

endpackage

// File: rtl/avalon_bus_arbiter_id_fifo.sv
// arb_id_fifo: RD_DEPTH x 1-bit FIFO of requester IDs for outstanding reads.
module arb_id_fifo
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_DEPTH = 4,
  localparam int unsigned PtrW    = $clog2(RD_DEPTH),
  localparam int unsigned CntW    = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  arb_id_e         i_push_id,
  input  logic            i_pop,
  output arb_id_e         o_head,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  arb_id_e         r_mem [RD_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CntW'(RD_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_push_id;
    end
  end

  // Pointers are PtrW bits wide, so increment wraps modulo RD_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave Avalon-MM arbiter with read-ID tracking.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed dbus priority.
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp,
  output logic         arb_resp_error
);

  localparam int unsigned CntW = $clog2(RD_DEPTH) + 1;

  arb_state_e r_state;
  arb_id_e    r_owner;
  logic       r_resp_error;
`ifdef ARB_ROUND_ROBIN_EN
  arb_id_e    r_last;
`endif

  arb_id_e         w_head;
  logic [CntW-1:0] w_count;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_i_act;
  logic            w_d_act;
  logic            w_i_elig;
  logic            w_d_elig;
  logic            w_sel_valid;
  arb_id_e         w_sel;
  logic            w_accept;
  logic            w_push;
  logic            w_rdv_ok;

  assign w_i_act  = req_active(ibus_avalon_req);
  assign w_d_act  = req_active(dbus_avalon_req);
  assign w_i_elig = req_eligible(ibus_avalon_req, w_fifo_full);
  assign w_d_elig = req_eligible(dbus_avalon_req, w_fifo_full);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = ARB_ID_DBUS;
    if (r_state == ARB_LOCKED) begin
      w_sel_valid = 1'b1;
      w_sel       = r_owner;
    end else if (w_i_elig && w_d_elig) begin
      w_sel_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      w_sel       = (r_last == ARB_ID_DBUS) ? ARB_ID_IBUS : ARB_ID_DBUS;
`else
      w_sel       = ARB_ID_DBUS;
`endif
    end else if (w_d_elig) begin
      w_sel_valid = 1'b1;
      w_sel       = ARB_ID_DBUS;
    end else if (w_i_elig) begin
      w_sel_valid = 1'b1;
      w_sel       = ARB_ID_IBUS;
    end
  end

  always_comb begin
    mem_avalon_req = '0;
    if (w_sel_valid) begin
      mem_avalon_req = (w_sel == ARB_ID_IBUS) ? ibus_avalon_req : dbus_avalon_req;
    end
  end

  assign w_accept = w_sel_valid & ~mem_avalon_resp.waitrequest;
  assign w_push   = w_accept & mem_avalon_req.read;
  assign w_rdv_ok = mem_avalon_resp.readdatavalid & ~w_fifo_empty;

  // readdata is broadcast; only readdatavalid is steered by the FIFO head.
  always_comb begin
    ibus_avalon_resp.readdata      = mem_avalon_resp.readdata;
    dbus_avalon_resp.readdata      = mem_avalon_resp.readdata;
    ibus_avalon_resp.readdatavalid = w_rdv_ok & (w_head == ARB_ID_IBUS);
    dbus_avalon_resp.readdatavalid = w_rdv_ok & (w_head == ARB_ID_DBUS);
    ibus_avalon_resp.waitrequest   = (w_sel_valid && w_sel == ARB_ID_IBUS)
                                     ? mem_avalon_resp.waitrequest : w_i_act;
    dbus_avalon_resp.waitrequest   = (w_sel_valid && w_sel == ARB_ID_DBUS)
                                     ? mem_avalon_resp.waitrequest : w_d_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= ARB_ID_DBUS;
      r_resp_error <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last       <= ARB_ID_DBUS;
`endif
    end else begin
      r_resp_error <= mem_avalon_resp.readdatavalid & (w_count == '0);
`ifdef ARB_ROUND_ROBIN_EN
      if (w_accept) r_last <= w_sel;
`endif
      unique case (r_state)
        ARB_IDLE: begin
          if (w_sel_valid && mem_avalon_resp.waitrequest) begin
            r_state <= ARB_LOCKED;
            r_owner <= w_sel;
          end
        end
        ARB_LOCKED: begin
          if (!mem_avalon_resp.waitrequest) r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign arb_resp_error = r_resp_error;

  arb_id_fifo #(
    .RD_DEPTH (RD_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_push_id (w_sel),
    .i_pop     (mem_avalon_resp.readdatavalid),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

endmodule
